// File: rtl/jacobi_input_loader.sv
// Jacobi front-end loader: streams the 36 upper-triangle elements into working
// memory (sign-extended to Q(1.4.15)), writes V = identity behind them, then pulses done.
module jacobi_input_loader #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 20,
  parameter int N        = 8,
  parameter int N_INPUT  = 36,
  parameter int V_OFFSET = 36,
  parameter int ADDR_W   = 7,
  parameter int FRAC     = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IN_W-1:0]   in_dat_i,
  input  logic              in_last_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [OUT_W-1:0]  wr_dat_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int LOG_N = $clog2(N);
  localparam int CNT_W = 2 * LOG_N;
  localparam logic [CNT_W-1:0] LAST_A  = CNT_W'(N_INPUT - 1);
  localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(N * N - 1);
  localparam logic [OUT_W-1:0] ONE_FIX = OUT_W'(1) << FRAC;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_A = 2'd1,
    S_INIT_V = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [OUT_W-1:0]    wr_dat_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                beat_d;
  logic [OUT_W-1:0]    ext_d;
  logic                diag_d;
  logic [ADDR_W-1:0]   v_addr_d;

  assign in_ready_o = (state_q == S_LOAD_A);
  assign beat_d     = in_ready_o & in_valid_i;
  assign ext_d      = {{(OUT_W - IN_W){in_dat_i[IN_W-1]}}, in_dat_i};
  // In INIT_V the counter is j: upper bits are the row, lower bits the column.
  assign diag_d     = (cnt_q[CNT_W-1:LOG_N] == cnt_q[LOG_N-1:0]);
  assign v_addr_d   = ADDR_W'(V_OFFSET) + ADDR_W'(cnt_q);

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_dat_o  = wr_dat_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_dat_q  <= {OUT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_LOAD_A;
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD_A: begin
          if (beat_d) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_W'(cnt_q);
            wr_dat_q  <= ext_d;
            // in_last must coincide exactly with the final element; anything else is a framing error
            if (in_last_i != (cnt_q == LAST_A)) begin
              err_q <= 1'b1;
            end
            if (cnt_q == LAST_A) begin
              state_q <= S_INIT_V;
              cnt_q   <= {CNT_W{1'b0}};
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_INIT_V: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= v_addr_d;
          wr_dat_q  <= diag_d ? ONE_FIX : {OUT_W{1'b0}};
          if (cnt_q == LAST_V) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_input_loader.sv
// Self-checking bench for jacobi_input_loader: randomized streams compared against
// an address-level model of the 100-word memory image and the cycle budget of a load.
module tb_jacobi_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dat;
  logic        in_last;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [19:0] wr_dat;
  logic        busy;
  logic        done;
  logic        err;

  jacobi_input_loader dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_dat_i   (in_dat),
    .in_last_i  (in_last),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_dat_o   (wr_dat),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus knobs
  logic [15:0] stim [36];
  int          last_pos;
  int          gap_pct;
  int          poke_a;
  int          poke_b;

  // observations from one load
  int          w_addr [$];
  logic [19:0] w_dat  [$];
  int          w_cyc  [$];
  int          beat_cyc [36];
  int          done_cyc, done_cnt, err_first, ready_bad, busy_bad, idle_cnt;
  logic        err_c1, err_end;

  // Reference: Q(1.0.15) value as a signed integer, re-encoded in 20 bits.
  function automatic logic [19:0] sext_model(input logic [15:0] x);
    int v;
    v = int'(x);
    if (v >= 32768) v = v - 65536;
    return 20'(v);
  endfunction

  function automatic logic [19:0] exp_wdat(input int a);
    int j;
    if (a < 36) return sext_model(stim[a]);
    j = a - 36;
    return ((j / 8) == (j % 8)) ? 20'd32768 : 20'd0;
  endfunction

  function automatic int write_errs();
    int e;
    e = 0;
    if (w_addr.size() != 100) return 100;
    for (int i = 0; i < 100; i++)
      if (w_addr[i] != i || w_dat[i] !== exp_wdat(i)) e++;
    return e;
  endfunction

  // Cycle c = value presented to posedge c, the start edge being c=0; sampled on negedges.
  task automatic run_load();
    int  beat;
    logic exp_ready;
    w_addr.delete(); w_dat.delete(); w_cyc.delete();
    done_cyc = -1; done_cnt = 0; err_first = -1; ready_bad = 0; busy_bad = 0; idle_cnt = 0;
    err_c1 = 1'b0; err_end = 1'b0; beat = 0;
    for (int i = 0; i < 36; i++) beat_cyc[i] = -1;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = (cyc == poke_a || cyc == poke_b) ? 1'b1 : 1'b0;
      if (wr_en) begin
        w_addr.push_back(int'(wr_addr)); w_dat.push_back(wr_dat); w_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err && err_first < 0) err_first = cyc;
      if (cyc == 1) err_c1 = err;
      err_end = err;
      exp_ready = (beat < 36);
      if (in_ready !== exp_ready) ready_bad++;
      if (busy !== (done_cyc < 0)) busy_bad++;
      if (exp_ready) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        in_dat   = stim[beat];
        in_last  = (beat == last_pos);
        if (in_valid) begin
          beat_cyc[beat] = cyc;
          beat++;
        end else begin
          idle_cnt++;
        end
      end else begin
        in_valid = 1'($urandom_range(1));
        in_last  = 1'($urandom_range(1));
        in_dat   = 16'($urandom);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic set_knobs(input int lp, input int gp);
    last_pos = lp; gap_pct = gp; poke_a = -1; poke_b = -1;
    for (int i = 0; i < 36; i++) stim[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_dat = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_dat, busy, done, err} !== 32'd0)
      $display("FAIL reset_values: got %h want 0", {in_ready, wr_en, wr_addr, wr_dat, busy, done, err});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, wr_en, busy, done, err} !== 5'd0)
      $display("FAIL idle_after_reset: got %b want 00000", {in_ready, wr_en, busy, done, err});
    else n_pass++;
  endtask

  task automatic test_ramp();
    set_knobs(35, 0);
    for (int i = 0; i < 36; i++) stim[i] = 16'(i);
    run_load();
    n_checks++;
    if (write_errs() !== 0) $display("FAIL ramp_writes: got %0d bad writes want 0", write_errs());
    else n_pass++;
    n_checks++;
    if (done_cyc !== 102) $display("FAIL ramp_done_cycle: got %0d want 102", done_cyc);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL ramp_done_count: got %0d want 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (err_first !== -1) $display("FAIL ramp_err: err first high at cycle %0d want never", err_first);
    else n_pass++;
    n_checks++;
    if (ready_bad !== 0) $display("FAIL ramp_in_ready: got %0d wrong cycles want 0", ready_bad);
    else n_pass++;
    n_checks++;
    if (busy_bad !== 0) $display("FAIL ramp_busy: got %0d wrong cycles want 0", busy_bad);
    else n_pass++;
    n_checks++;
    if (w_cyc.size() != 100 || w_cyc[36] !== w_cyc[35] + 1 || w_cyc[99] !== 101)
      $display("FAIL ramp_handover: got %0d writes want 100 back-to-back ending at cycle 101", w_cyc.size());
    else n_pass++;
  endtask

  task automatic test_sign_ext();
    set_knobs(35, 0);
    stim[0] = 16'h8000; stim[1] = 16'hFFFF; stim[2] = 16'h7FFF;
    run_load();
    n_checks++;
    if (w_dat.size() < 3 || w_dat[0] !== 20'hF8000) $display("FAIL sext_8000: got %h want f8000", w_dat[0]);
    else n_pass++;
    n_checks++;
    if (w_dat.size() < 3 || w_dat[1] !== 20'hFFFFF) $display("FAIL sext_ffff: got %h want fffff", w_dat[1]);
    else n_pass++;
    n_checks++;
    if (w_dat.size() < 3 || w_dat[2] !== 20'h07FFF) $display("FAIL sext_7fff: got %h want 07fff", w_dat[2]);
    else n_pass++;
    n_checks++;
    if (write_errs() !== 0) $display("FAIL sext_writes: got %0d bad writes want 0", write_errs());
    else n_pass++;
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 2; r++) begin
      set_knobs(35, 30 + 20 * r);
      run_load();
      n_checks++;
      if (write_errs() !== 0) $display("FAIL gaps_writes: got %0d bad writes want 0", write_errs());
      else n_pass++;
      n_checks++;
      if (done_cyc !== 102 + idle_cnt) $display("FAIL gaps_done_cycle: got %0d want %0d", done_cyc, 102 + idle_cnt);
      else n_pass++;
      n_checks++;
      if (ready_bad !== 0 || busy_bad !== 0 || done_cnt !== 1)
        $display("FAIL gaps_handshake: got ready_bad=%0d busy_bad=%0d dones=%0d want 0/0/1", ready_bad, busy_bad, done_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_framing();
    set_knobs(10, 20);
    run_load();
    n_checks++;
    if (err_first !== beat_cyc[10] + 1) $display("FAIL early_last_err_cycle: got %0d want %0d", err_first, beat_cyc[10] + 1);
    else n_pass++;
    n_checks++;
    if (write_errs() !== 0 || done_cnt !== 1)
      $display("FAIL early_last_completes: got %0d bad writes, %0d dones want 0, 1", write_errs(), done_cnt);
    else n_pass++;
    n_checks++;
    if (err_end !== 1'b1) $display("FAIL early_last_sticky: got %b want 1", err_end);
    else n_pass++;
    set_knobs(35, 0);
    run_load();
    n_checks++;
    if (err_c1 !== 1'b0 || err_end !== 1'b0) $display("FAIL start_clears_err: got %b%b want 00", err_c1, err_end);
    else n_pass++;
    set_knobs(-1, 20);
    run_load();
    n_checks++;
    if (err_first !== beat_cyc[35] + 1 || err_end !== 1'b1)
      $display("FAIL missing_last_err: got first=%0d end=%b want %0d/1", err_first, err_end, beat_cyc[35] + 1);
    else n_pass++;
    n_checks++;
    if (write_errs() !== 0) $display("FAIL missing_last_writes: got %0d bad writes want 0", write_errs());
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    set_knobs(35, 0);
    poke_a = 10; poke_b = 60;
    run_load();
    n_checks++;
    if (write_errs() !== 0) $display("FAIL start_ignored_writes: got %0d bad writes want 0", write_errs());
    else n_pass++;
    n_checks++;
    if (done_cyc !== 102 || done_cnt !== 1)
      $display("FAIL start_ignored_done: got cycle %0d count %0d want 102/1", done_cyc, done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stray;
    set_knobs(35, 0);
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_dat   = stim[cyc - 1];
      in_last  = 1'b0;
      if (cyc == 21) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({wr_en, busy, in_ready} !== 3'b000) $display("FAIL reset_mid_outputs: got %b want 000", {wr_en, busy, in_ready});
    else n_pass++;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en) stray++;
    end
    n_checks++;
    if (stray !== 0) $display("FAIL reset_mid_no_writes: got %0d writes want 0", stray);
    else n_pass++;
    set_knobs(35, 10);
    run_load();
    n_checks++;
    if (write_errs() !== 0 || done_cyc !== 102 + idle_cnt)
      $display("FAIL reload_after_reset: got %0d bad writes, done %0d want 0, %0d", write_errs(), done_cyc, 102 + idle_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_sign_ext();
    test_gaps();
    test_framing();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
